// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory read port with wait-request handshake.
// The master side is the fetch sequencer and the slave side is the instruction memory.
interface pc_fetch_sequencer_if;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_waitrequest,
    output mem_readdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch sequencer: owns the PC, fetches over a wait-request port,
// holds each instruction until the datapath finishes, and orders branch delay slots.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        rst,
  pc_fetch_sequencer_if.master        mem,
  output logic [31:0]                 instr,
  output logic                        instr_valid,
  input  logic                        exec_done,
  input  logic                        br_taken,
  input  logic [31:0]                 br_target,
  output logic [31:0]                 pc,
  output logic                        active
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  logic        read_q;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        unused_target_bits;

  assign unused_target_bits = ^br_target[1:0];

  // The request is held in a register; reset gates it off combinationally so no fetch leaks out during rst.
  assign mem.mem_read = read_q & ~rst;
  assign mem.mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_VECTOR;
      instr       <= 32'h0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      read_q      <= 1'b1;
      instr_valid <= 1'b0;
      active      <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (!mem.mem_waitrequest) begin
            instr       <= mem.mem_readdata;
            state       <= EXEC;
            read_q      <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (pend_valid) begin
              // Delay slot retiring: take the pending redirect and ignore this instruction's own br_taken.
              pc         <= pend_target;
              pend_valid <= 1'b0;
              if (pend_target == HALT_ADDR) begin
                state  <= HALT;
                read_q <= 1'b0;
                active <= 1'b0;
              end else begin
                state  <= FETCH;
                read_q <= 1'b1;
              end
            end else begin
              pc     <= pc + 32'd4;
              state  <= FETCH;
              read_q <= 1'b1;
              if (br_taken) begin
                pend_valid  <= 1'b1;
                pend_target <= {br_target[31:2], 2'b00};
              end
            end
          end
        end
        HALT: begin
          read_q      <= 1'b0;
          instr_valid <= 1'b0;
          active      <= 1'b0;
        end
        default: begin
          state  <= FETCH;
          read_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against a transaction-level PC/delay-slot model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h00000000;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        active;

  int checks;
  int failures;
  int cycles;

  // Reference model: architectural PC, pending redirect, halted flag, last captured word.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_target;
  logic        m_halted;
  logic [31:0] m_instr;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR(RV),
    .HALT_ADDR(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus),
    .instr(instr),
    .instr_valid(instr_valid),
    .exec_done(exec_done),
    .br_taken(br_taken),
    .br_target(br_target),
    .pc(pc),
    .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycles = 0;
  always @(posedge clk) cycles <= cycles + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycles);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    exec_done = 1'b0;
    br_taken = 1'b0;
    bus.mem_waitrequest = 1'b0;
    #1;
    checkOutput("rst_read_gated", {31'b0, bus.mem_read}, 32'd0);
    step();
    checkOutput("rst_pc", pc, RV);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_active", {31'b0, active}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("first_read", {31'b0, bus.mem_read}, 32'd1);
    checkOutput("first_addr", bus.mem_addr, RV);
    m_pc = RV;
    m_pend = 1'b0;
    m_target = 32'h0;
    m_halted = 1'b0;
    m_instr = 32'h0;
  endtask

  // One full instruction: fetch with waits, execute with stalls, retire with optional redirect.
  task automatic applyStimulus(input int waits, input int stalls, input bit br, input logic [31:0] tgt);
    logic [31:0] word;
    int start;
    start = cycles;
    word = $urandom;
    checkOutput("fetch_read", {31'b0, bus.mem_read}, 32'd1);
    checkOutput("fetch_addr", bus.mem_addr, m_pc);
    checkOutput("fetch_pc", pc, m_pc);
    checkOutput("fetch_nvalid", {31'b0, instr_valid}, 32'd0);
    checkOutput("fetch_active", {31'b0, active}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      bus.mem_waitrequest = 1'b1;
      bus.mem_readdata = $urandom;
      exec_done = $urandom_range(0, 1);
      step();
      checkOutput("wait_read", {31'b0, bus.mem_read}, 32'd1);
      checkOutput("wait_addr", bus.mem_addr, m_pc);
      checkOutput("wait_instr", instr, m_instr);
      checkOutput("wait_nvalid", {31'b0, instr_valid}, 32'd0);
    end
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = word;
    exec_done = 1'b0;
    step();
    m_instr = word;
    for (int i = 0; i <= stalls; i++) begin
      bus.mem_waitrequest = $urandom_range(0, 1);
      bus.mem_readdata = $urandom;
      checkOutput("exec_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("exec_instr", instr, m_instr);
      checkOutput("exec_noread", {31'b0, bus.mem_read}, 32'd0);
      checkOutput("exec_pc", pc, m_pc);
      if (i < stalls) begin
        exec_done = 1'b0;
        br_taken = $urandom_range(0, 1);
        br_target = $urandom;
        step();
      end
    end
    exec_done = 1'b1;
    br_taken = br;
    br_target = tgt;
    step();
    exec_done = 1'b0;
    br_taken = 1'b0;
    bus.mem_waitrequest = 1'b0;
    if (m_pend) begin
      m_pc = m_target;
      m_pend = 1'b0;
      m_halted = (m_target == HALT);
    end else begin
      m_pc = m_pc + 32'd4;
      if (br) begin
        m_pend = 1'b1;
        m_target = tgt & 32'hFFFFFFFC;
      end
    end
    checkOutput("instr_cycles", cycles - start, waits + stalls + 2);
    checkOutput("retire_pc", pc, m_pc);
    checkOutput("retire_active", {31'b0, active}, {31'b0, ~m_halted});
  endtask

  task automatic checkHalted(input int n);
    for (int i = 0; i < n; i++) begin
      exec_done = $urandom_range(0, 1);
      br_taken = $urandom_range(0, 1);
      br_target = $urandom;
      bus.mem_waitrequest = $urandom_range(0, 1);
      bus.mem_readdata = $urandom;
      #1;
      checkOutput("halt_noread", {31'b0, bus.mem_read}, 32'd0);
      checkOutput("halt_nvalid", {31'b0, instr_valid}, 32'd0);
      checkOutput("halt_active", {31'b0, active}, 32'd0);
      checkOutput("halt_pc", pc, HALT);
      step();
    end
    exec_done = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    exec_done = 1'b0;
    br_taken = 1'b0;
    br_target = 32'h0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = 32'h0;
    step();

    // Zero-wait sequential stream.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 32'h0);
    checkOutput("seq_addr", bus.mem_addr, 32'hBFC0000C);

    // Three wait-request cycles on the first fetch.
    applyReset();
    applyStimulus(3, 0, 1'b0, 32'h0);

    // Branch at BFC00010, delay slot tries its own branch which must be ignored.
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'b0, 32'h0);
    applyStimulus(0, 1, 1'b1, 32'hBFC00100);
    checkOutput("delay_slot_addr", bus.mem_addr, 32'hBFC00014);
    applyStimulus(1, 0, 1'b1, 32'h12345678);
    checkOutput("branch_target_addr", bus.mem_addr, 32'hBFC00100);
    applyStimulus(0, 0, 1'b0, 32'h0);

    // Jump to the halt address at BFC00020.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1'b0, 32'h0);
    applyStimulus(0, 0, 1'b1, HALT);
    applyStimulus(0, 0, 1'b0, 32'h0);
    checkHalted(4);

    // Misaligned redirect near the top of memory, then wrap through zero without halting.
    applyReset();
    applyStimulus(0, 0, 1'b1, 32'hFFFFFFFE);
    applyStimulus(0, 0, 1'b0, 32'h0);
    checkOutput("wrap_top_addr", bus.mem_addr, 32'hFFFFFFFC);
    applyStimulus(0, 0, 1'b0, 32'h0);
    checkOutput("wrap_zero_addr", bus.mem_addr, 32'h00000000);
    checkOutput("wrap_active", {31'b0, active}, 32'd1);
    applyStimulus(2, 0, 1'b0, 32'h0);
    checkOutput("wrap_next_addr", bus.mem_addr, 32'h00000004);

    // Reset during a wait-request cycle with a redirect pending.
    applyReset();
    applyStimulus(0, 0, 1'b1, 32'hBFC00800);
    bus.mem_waitrequest = 1'b1;
    step();
    rst = 1'b1;
    step();
    checkOutput("midrst_pc", pc, RV);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_instr", instr, 32'h0);
    rst = 1'b0;
    bus.mem_waitrequest = 1'b0;
    m_pc = RV;
    m_pend = 1'b0;
    m_halted = 1'b0;
    m_instr = 32'h0;
    #1;
    applyStimulus(0, 0, 1'b0, 32'h0);
    applyStimulus(0, 0, 1'b0, 32'h0);
    checkOutput("midrst_seq_addr", bus.mem_addr, 32'hBFC00008);

    // Randomized streams with branches, misaligned targets and occasional halts.
    applyReset();
    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        checkHalted(2);
        applyReset();
      end else begin
        logic [31:0] tgt;
        if ($urandom_range(0, 7) == 0) tgt = $urandom_range(0, 3);
        else tgt = $urandom;
        applyStimulus($urandom_range(0, 3), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0), tgt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
